// File: rtl/calculator_pkg.sv
// Shared constants and types for the calculator datapath and its sequencer.
package calculator_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned MEM_WORD_SIZE = 64;
    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned RD_LAT_DEF    = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        ADD   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/calc_sequencer.sv
// Control FSM: reads operand-pair words, steers two adder results into the
// halves of result_buffer, then writes the 64-bit buffer back to SRAM.
module calc_sequencer #(
    parameter int unsigned ADDR_W = calculator_pkg::ADDR_W,
    parameter int unsigned RD_LAT = calculator_pkg::RD_LAT_DEF
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [ADDR_W-1:0]                      read_start_addr_i,
    input  logic [ADDR_W-1:0]                      read_end_addr_i,
    input  logic [ADDR_W-1:0]                      write_start_addr_i,
    input  logic [calculator_pkg::MEM_WORD_SIZE-1:0] mem_rdata_i,
    output logic                                   mem_rd_o,
    output logic                                   mem_wr_o,
    output logic [ADDR_W-1:0]                      mem_addr_o,
    output logic [calculator_pkg::DATA_W-1:0]      op_a_o,
    output logic [calculator_pkg::DATA_W-1:0]      op_b_o,
    output logic                                   loc_sel_o,
    output logic                                   buffer_write_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   error_o
);

    import calculator_pkg::*;

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned NW    = ADDR_W + 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_end_q, rd_end_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              half_q, half_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              loc_sel_q, loc_sel_d;
    logic              buffer_write_q, buffer_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [NW-1:0]     n_words_c;
    logic              bad_req_c;

    // Operand words go straight from SRAM to the adder.
    assign op_a_o = mem_rdata_i[DATA_W-1:0];
    assign op_b_o = mem_rdata_i[2*DATA_W-1:DATA_W];

    assign mem_rd_o       = mem_rd_q;
    assign mem_wr_o       = mem_wr_q;
    assign mem_addr_o     = mem_addr_q;
    assign loc_sel_o      = loc_sel_q;
    assign buffer_write_o = buffer_write_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;

    // Next-state, pointer update, and output decode from the next state.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rd_end_d  = rd_end_q;
        wr_ptr_d  = wr_ptr_q;
        half_d    = half_q;
        cnt_d     = cnt_q;
        error_d   = 1'b0;

        n_words_c = NW'(read_end_addr_i) - NW'(read_start_addr_i) + NW'(1);
        bad_req_c = (read_end_addr_i < read_start_addr_i) || n_words_c[0];

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (bad_req_c) begin
                        error_d = 1'b1;
                    end else begin
                        rd_ptr_d = read_start_addr_i;
                        rd_end_d = read_end_addr_i;
                        wr_ptr_d = write_start_addr_i;
                        half_d   = 1'b0;
                        state_d  = READ;
                    end
                end
            end
            READ: begin
                if (RD_LAT == 1) begin
                    state_d = ADD;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADD: begin
                if (!half_q) begin
                    half_d   = 1'b1;
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    state_d  = READ;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (rd_ptr_q == rd_end_q) begin
                    state_d = DONE;
                end else begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    half_d   = 1'b0;
                    state_d  = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered Moore outputs: decode the state being entered.
        mem_rd_d       = (state_d == READ);
        mem_wr_d       = (state_d == WRITE);
        mem_addr_d     = (state_d == READ)  ? rd_ptr_d :
                         (state_d == WRITE) ? wr_ptr_d : '0;
        loc_sel_d      = (state_d == ADD) && half_d;
        buffer_write_d = (state_d != ADD);
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
    end

    // State, pointer and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            rd_end_q       <= '0;
            wr_ptr_q       <= '0;
            half_q         <= 1'b0;
            cnt_q          <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            loc_sel_q      <= 1'b0;
            buffer_write_q <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_end_q       <= rd_end_d;
            wr_ptr_q       <= wr_ptr_d;
            half_q         <= half_d;
            cnt_q          <= cnt_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            mem_addr_q     <= mem_addr_d;
            loc_sel_q      <= loc_sel_d;
            buffer_write_q <= buffer_write_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

endmodule
